btn_fifo_ctrl: RTL and testbench

Button-driven FIFO access controller. It sits directly downstream of the push-button debouncers. Each debounced push or pop pulse becomes exactly one single-cycle write or read request to the asynchronous FIFO's port in the `clk` domain. Requests against a full or empty FIFO are blocked, and the last popped word is held for the display.

---
 rtl/btn_fifo_pkg.sv | 14 +
 rtl/btn_sync_edge.sv | 23 ++
 rtl/btn_fifo_ctrl.sv | 145 ++++++++++++++
 tb/tb_btn_fifo_ctrl.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/btn_fifo_pkg.sv
// Shared types and constants for the button-driven FIFO access controller.
// Optional feature macro used by btn_fifo_ctrl: DATA_AUTOINC_EN.
package btn_fifo_pkg;

   localparam int DATA_W_DEF = 8;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      WRITE   = 2'd1,
      READ    = 2'd2,
      CAPTURE = 2'd3
   } state_e;

endpackage

// File: rtl/btn_sync_edge.sv
// Two-flop synchroniser plus delay flop; emits a one-cycle strobe on each
// rising edge of an asynchronous button level.
module btn_sync_edge (
   input  logic clk,
   input  logic reset,
   input  logic btn,
   output logic strobe
);

   // sync_q[0] = s1, sync_q[1] = s2, sync_q[2] = s3 (delay flop)
   logic [2:0] sync_q;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sync_q <= '0;
      end else begin
         sync_q <= {sync_q[1:0], btn};
      end
   end

   assign strobe = sync_q[1] & ~sync_q[2];

endmodule

// File: rtl/btn_fifo_ctrl.sv
// Turns debounced push/pop buttons into single-cycle FIFO write/read strobes,
// blocks requests against full/empty, and holds the last popped word.
// Build option: define DATA_AUTOINC_EN to write an incrementing counter
// instead of the switch value.
module btn_fifo_ctrl
   import btn_fifo_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              push_btn,
   input  logic              pop_btn,
   input  logic [DATA_W-1:0] sw_data,
   input  logic              fifo_full,
   input  logic              fifo_empty,
   input  logic [DATA_W-1:0] rd_data,
   input  logic              clr_err,
   output logic              wr_en,
   output logic [DATA_W-1:0] wr_data,
   output logic              rd_en,
   output logic [DATA_W-1:0] disp_data,
   output logic              ovf_err,
   output logic              udf_err
);

   state_e            state_q, state_d;
   logic              push_pend_q, push_pend_d;
   logic              pop_pend_q, pop_pend_d;
   logic              wr_en_q, wr_en_d;
   logic              rd_en_q, rd_en_d;
   logic [DATA_W-1:0] wr_data_q, wr_data_d;
   logic [DATA_W-1:0] disp_q, disp_d;
   logic              ovf_q, ovf_d;
   logic              udf_q, udf_d;
   logic              push_stb, pop_stb;
   logic              push_take, pop_take;
   logic              ovf_set, udf_set;

   btn_sync_edge u_push_sync (
      .clk    (clk),
      .reset  (reset),
      .btn    (push_btn),
      .strobe (push_stb)
   );

   btn_sync_edge u_pop_sync (
      .clk    (clk),
      .reset  (reset),
      .btn    (pop_btn),
      .strobe (pop_stb)
   );

   always_comb begin
      state_d   = state_q;
      push_take = 1'b0;
      pop_take  = 1'b0;
      ovf_set   = 1'b0;
      udf_set   = 1'b0;
      wr_en_d   = 1'b0;
      rd_en_d   = 1'b0;
      wr_data_d = wr_data_q;
      disp_d    = disp_q;

      case (state_q)
         IDLE: begin
            // Push wins; a concurrent pop stays pending for a later IDLE.
            if (push_pend_q) begin
               push_take = 1'b1;
               if (fifo_full) begin
                  ovf_set = 1'b1;
               end else begin
                  state_d = WRITE;
                  wr_en_d = 1'b1;
`ifndef DATA_AUTOINC_EN
                  wr_data_d = sw_data;
`endif
               end
            end else if (pop_pend_q) begin
               pop_take = 1'b1;
               if (fifo_empty) begin
                  udf_set = 1'b1;
               end else begin
                  state_d = READ;
                  rd_en_d = 1'b1;
               end
            end
         end
         WRITE: begin
            state_d = IDLE;
`ifdef DATA_AUTOINC_EN
            wr_data_d = wr_data_q + DATA_W'(1);
`endif
         end
         READ: begin
            state_d = CAPTURE;
         end
         CAPTURE: begin
            disp_d  = rd_data;
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      // A new strobe re-arms the flag even in the cycle the old one is taken.
      push_pend_d = push_stb | (push_pend_q & ~push_take);
      pop_pend_d  = pop_stb  | (pop_pend_q  & ~pop_take);
      ovf_d       = ovf_set  | (ovf_q & ~clr_err);
      udf_d       = udf_set  | (udf_q & ~clr_err);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= IDLE;
         push_pend_q <= 1'b0;
         pop_pend_q  <= 1'b0;
         wr_en_q     <= 1'b0;
         rd_en_q     <= 1'b0;
         wr_data_q   <= '0;
         disp_q      <= '0;
         ovf_q       <= 1'b0;
         udf_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         push_pend_q <= push_pend_d;
         pop_pend_q  <= pop_pend_d;
         wr_en_q     <= wr_en_d;
         rd_en_q     <= rd_en_d;
         wr_data_q   <= wr_data_d;
         disp_q      <= disp_d;
         ovf_q       <= ovf_d;
         udf_q       <= udf_d;
      end
   end

   assign wr_en     = wr_en_q;
   assign rd_en     = rd_en_q;
   assign wr_data   = wr_data_q;
   assign disp_data = disp_q;
   assign ovf_err   = ovf_q;
   assign udf_err   = udf_q;

endmodule

// File: tb/tb_btn_fifo_ctrl.sv
// Directed self-checking bench for btn_fifo_ctrl: push/pop timing, blocking,
// error flags, simultaneous requests, mid-transfer reset and auto-increment.
module tb_btn_fifo_ctrl;

   localparam int DW = 8;

   logic          clk        = 1'b0;
   logic          reset      = 1'b0;
   logic          push_btn   = 1'b0;
   logic          pop_btn    = 1'b0;
   logic          fifo_full  = 1'b0;
   logic          fifo_empty = 1'b0;
   logic          clr_err    = 1'b0;
   logic [DW-1:0] sw_data    = '0;
   logic [DW-1:0] rd_data    = '0;
   logic [DW-1:0] rd_word    = '0;

   logic          wr_en, rd_en, ovf_err, udf_err;
   logic [DW-1:0] wr_data, disp_data;

   int vectors     = 0;
   int miscompares = 0;
   int wr_pulses   = 0;
   int rd_pulses   = 0;
   int overlap     = 0;
   int base_wr     = 0;
   int base_rd     = 0;

   always #5 clk = ~clk;

   btn_fifo_ctrl #(.DATA_W(DW)) dut (
      .clk        (clk),
      .reset      (reset),
      .push_btn   (push_btn),
      .pop_btn    (pop_btn),
      .sw_data    (sw_data),
      .fifo_full  (fifo_full),
      .fifo_empty (fifo_empty),
      .rd_data    (rd_data),
      .clr_err    (clr_err),
      .wr_en      (wr_en),
      .wr_data    (wr_data),
      .rd_en      (rd_en),
      .disp_data  (disp_data),
      .ovf_err    (ovf_err),
      .udf_err    (udf_err)
   );

   // FIFO read port model: word appears the cycle after rd_en.
   always @(posedge clk) begin
      if (wr_en) wr_pulses <= wr_pulses + 1;
      if (rd_en) begin
         rd_pulses <= rd_pulses + 1;
         rd_data   <= rd_word;
      end
      if (wr_en && rd_en) overlap <= overlap + 1;
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One-cycle push pulse, then wait (bounded) for its write strobe.
   task automatic push_expect(input string tag, input logic [DW-1:0] exp_data);
      logic found;
      found = 1'b0;
      push_btn = 1'b1;
      step();
      push_btn = 1'b0;
      for (int k = 0; k < 8; k++) begin
         step();
         if (wr_en === 1'b1) begin
            found = 1'b1;
            break;
         end
      end
      chk({tag, "_seen"}, {31'd0, found}, 32'd1);
      if (found) chk({tag, "_data"}, {24'd0, wr_data}, {24'd0, exp_data});
      step();
   endtask

   initial begin
      // ---------------- reset state ----------------
      reset = 1'b0;
      step();
      step();
      chk("rst_wr_en", {31'd0, wr_en}, 32'd0);
      chk("rst_rd_en", {31'd0, rd_en}, 32'd0);
      chk("rst_wr_data", {24'd0, wr_data}, 32'd0);
      chk("rst_disp", {24'd0, disp_data}, 32'd0);
      chk("rst_ovf", {31'd0, ovf_err}, 32'd0);
      chk("rst_udf", {31'd0, udf_err}, 32'd0);
      reset = 1'b1;
      step();
      step();

      // ---------------- push, long pulse ----------------
      sw_data  = 8'h5A;
      base_wr  = wr_pulses;
      push_btn = 1'b1;
      step();                                   // E0
      chk("push_e0", {31'd0, wr_en}, 32'd0);
      step();                                   // E1
      step();                                   // E2
      chk("push_e2", {31'd0, wr_en}, 32'd0);
      step();                                   // E3
      chk("push_e3_wr_en", {31'd0, wr_en}, 32'd1);
`ifdef DATA_AUTOINC_EN
      chk("push_e3_data", {24'd0, wr_data}, 32'h00);
`else
      chk("push_e3_data", {24'd0, wr_data}, 32'h5A);
`endif
      step();                                   // E4
      chk("push_e4_wr_en", {31'd0, wr_en}, 32'd0);
      repeat (35) step();
      push_btn = 1'b0;
      repeat (6) step();
      chk("push_one_pulse", wr_pulses - base_wr, 32'd1);

      // ---------------- pop ----------------
      rd_word = 8'hC3;
      base_rd = rd_pulses;
      pop_btn = 1'b1;
      step();                                   // E0
      pop_btn = 1'b0;
      step();                                   // E1
      step();                                   // E2
      chk("pop_e2_rd_en", {31'd0, rd_en}, 32'd0);
      step();                                   // E3
      chk("pop_e3_rd_en", {31'd0, rd_en}, 32'd1);
      step();                                   // E4
      chk("pop_e4_rd_en", {31'd0, rd_en}, 32'd0);
      chk("pop_e4_disp", {24'd0, disp_data}, 32'h00);
      step();                                   // E5
      chk("pop_e5_disp", {24'd0, disp_data}, 32'hC3);
      repeat (4) step();
      chk("pop_one_pulse", rd_pulses - base_rd, 32'd1);

      // ---------------- full blocking, set beats clear ----------------
      fifo_full = 1'b1;
      base_wr   = wr_pulses;
      push_btn  = 1'b1;
      step();                                   // E0
      push_btn = 1'b0;
      step();                                   // E1
      step();                                   // E2
      chk("full_ovf_pre", {31'd0, ovf_err}, 32'd0);
      clr_err = 1'b1;
      step();                                   // E3: set and clear together
      clr_err = 1'b0;
      chk("full_ovf_set_wins", {31'd0, ovf_err}, 32'd1);
      chk("full_no_wr_en", {31'd0, wr_en}, 32'd0);
      repeat (4) step();
      chk("full_ovf_sticky", {31'd0, ovf_err}, 32'd1);
      chk("full_no_write", wr_pulses - base_wr, 32'd0);
      fifo_full = 1'b0;
      clr_err   = 1'b1;
      step();
      clr_err = 1'b0;
      chk("clr_ovf", {31'd0, ovf_err}, 32'd0);

      // ---------------- empty blocking ----------------
      fifo_empty = 1'b1;
      base_rd    = rd_pulses;
      pop_btn    = 1'b1;
      step();
      pop_btn = 1'b0;
      repeat (6) step();
      chk("empty_udf", {31'd0, udf_err}, 32'd1);
      chk("empty_no_read", rd_pulses - base_rd, 32'd0);
      chk("empty_ovf_clear", {31'd0, ovf_err}, 32'd0);
      fifo_empty = 1'b0;
      clr_err    = 1'b1;
      step();
      clr_err = 1'b0;
      chk("clr_udf", {31'd0, udf_err}, 32'd0);

      // ---------------- simultaneous push and pop ----------------
      sw_data  = 8'h11;
      rd_word  = 8'h7E;
      push_btn = 1'b1;
      pop_btn  = 1'b1;
      step();                                   // E0
      push_btn = 1'b0;
      pop_btn  = 1'b0;
      step();                                   // E1
      step();                                   // E2
      step();                                   // E3
      chk("sim_e3_wr_en", {31'd0, wr_en}, 32'd1);
      chk("sim_e3_rd_en", {31'd0, rd_en}, 32'd0);
`ifdef DATA_AUTOINC_EN
      chk("sim_e3_data", {24'd0, wr_data}, 32'h01);
`else
      chk("sim_e3_data", {24'd0, wr_data}, 32'h11);
`endif
      step();                                   // E4
      chk("sim_e4_rd_en", {31'd0, rd_en}, 32'd0);
      step();                                   // E5
      chk("sim_e5_rd_en", {31'd0, rd_en}, 32'd1);
      step();                                   // E6
      chk("sim_e6_disp", {24'd0, disp_data}, 32'hC3);
      step();                                   // E7
      chk("sim_e7_disp", {24'd0, disp_data}, 32'h7E);
      repeat (3) step();

      // ---------------- reset during WRITE ----------------
      sw_data  = 8'hA5;
      push_btn = 1'b1;
      step();                                   // E0
      push_btn = 1'b0;
      step();
      step();
      step();                                   // E3
      chk("rstmid_wr_en_before", {31'd0, wr_en}, 32'd1);
      base_wr = wr_pulses;
      base_rd = rd_pulses;
      #1 reset = 1'b0;
      #1;
      chk("rstmid_wr_en", {31'd0, wr_en}, 32'd0);
      chk("rstmid_wr_data", {24'd0, wr_data}, 32'd0);
      chk("rstmid_disp", {24'd0, disp_data}, 32'd0);
      step();
      step();
      reset = 1'b1;
      repeat (10) step();
      chk("rstmid_no_write", wr_pulses - base_wr, 32'd0);
      chk("rstmid_no_read", rd_pulses - base_rd, 32'd0);

`ifdef DATA_AUTOINC_EN
      // ---------------- auto-increment: 257 pushes, one blocked ----------------
      for (int i = 0; i < 257; i++) begin
         if (i == 100) begin
            fifo_full = 1'b1;
            base_wr   = wr_pulses;
            push_btn  = 1'b1;
            step();
            push_btn = 1'b0;
            repeat (6) step();
            chk("autoinc_blocked", wr_pulses - base_wr, 32'd0);
            fifo_full = 1'b0;
         end
         push_expect("autoinc", DW'(i % 256));
      end
`endif

      chk("never_wr_rd_overlap", overlap, 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
